// File: rtl/spi_pwm_core.sv
// spi_pwm_core: complementary, dead-time-protected PWM generator fed from the
// SPI register bank (ctrl, period, duty). The configuration is double-buffered
// and committed only at period boundaries, so SPI writes cannot glitch a pulse.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   ctrl_i        [0] enable, [1] polarity invert, [3:2] dead time, [7:4] prescale
//   period_i      period value N (period is N+1 ticks)
//   duty_i        high-side on-time D in ticks
//   pwm_o         high-side pin (registered)
//   pwm_n_o       low-side pin (registered)
//   period_done_o one-clk pulse on the first clk of each new period
//   cnt_o         current period counter
module spi_pwm_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ctrl_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] duty_i,
  output logic             pwm_o,
  output logic             pwm_n_o,
  output logic             period_done_o,
  output logic [WIDTH-1:0] cnt_o
);

  // Shadow (active) configuration
  logic             en_sh_q, en_sh_d;
  logic             pol_sh_q, pol_sh_d;
  logic [1:0]       dt_sh_q, dt_sh_d;
  logic [3:0]       presc_sh_q, presc_sh_d;
  logic [WIDTH-1:0] period_sh_q, period_sh_d;
  logic [WIDTH-1:0] duty_sh_q, duty_sh_d;

  // Timebase
  logic [3:0]       presc_cnt_q, presc_cnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Output stage
  logic             raw_q, raw_d;
  logic             raw_vld_q, raw_vld_d;  // raw_q reflects a real enabled-period compare
  logic             tgt_q, tgt_d;          // state the output stage is currently driving toward
  logic             tgt_vld_q, tgt_vld_d;  // clear until the first state after enable is taken
  logic [1:0]       dt_cnt_q, dt_cnt_d;
  logic             hi_q, hi_d;
  logic             lo_q, lo_d;
  logic             pwm_q, pwm_d;
  logic             pwm_n_q, pwm_n_d;

  logic tick, wrap, load_sh, raw;

  assign tick    = en_sh_q && (presc_cnt_q == presc_sh_q);
  assign wrap    = tick && (cnt_q == period_sh_q);
  assign load_sh = !en_sh_q || wrap;
  assign raw     = (cnt_q < duty_sh_q);

  always_comb begin
    // Enabled: stays set unless ctrl_i[0] drops; disabled: follows ctrl_i[0].
    // Both cases reduce to tracking ctrl_i[0] directly.
    en_sh_d     = ctrl_i[0];
    pol_sh_d    = pol_sh_q;
    dt_sh_d     = dt_sh_q;
    presc_sh_d  = presc_sh_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    if (load_sh) begin
      pol_sh_d    = ctrl_i[1];
      dt_sh_d     = ctrl_i[3:2];
      presc_sh_d  = ctrl_i[7:4];
      period_sh_d = period_i;
      duty_sh_d   = duty_i;
    end
  end

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    cnt_d       = cnt_q;
    done_d      = wrap;
    if (!en_sh_q) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
    end else if (tick) begin
      presc_cnt_d = '0;
      cnt_d       = wrap ? '0 : cnt_q + WIDTH'(1);
    end else begin
      presc_cnt_d = presc_cnt_q + 4'd1;
    end
  end

  always_comb begin
    raw_d     = en_sh_q ? raw : 1'b0;
    raw_vld_d = en_sh_q;
    tgt_d     = tgt_q;
    tgt_vld_d = tgt_vld_q;
    dt_cnt_d  = dt_cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (!en_sh_q || !raw_vld_q) begin
      tgt_d     = 1'b0;
      tgt_vld_d = 1'b0;
      dt_cnt_d  = '0;
      hi_d      = 1'b0;
      lo_d      = 1'b0;
    end else begin
      tgt_d     = raw_q;
      tgt_vld_d = 1'b1;
      if (!tgt_vld_q || (raw_q != tgt_q)) begin
        // New state (or first state after enable): break before make.
        if (dt_sh_q == 2'd0) begin
          hi_d     = raw_q;
          lo_d     = ~raw_q;
          dt_cnt_d = '0;
        end else begin
          hi_d     = 1'b0;
          lo_d     = 1'b0;
          dt_cnt_d = dt_sh_q;
        end
      end else if (dt_cnt_q != 2'd0) begin
        dt_cnt_d = dt_cnt_q - 2'd1;
        if (dt_cnt_q == 2'd1) begin
          hi_d = raw_q;
          lo_d = ~raw_q;
        end
      end
    end
    // Pins are flopped from the same next-state values so they track hi/lo and pol exactly.
    pwm_d   = hi_d ^ pol_sh_d;
    pwm_n_d = lo_d ^ pol_sh_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sh_q     <= 1'b0;
      pol_sh_q    <= 1'b0;
      dt_sh_q     <= '0;
      presc_sh_q  <= '0;
      period_sh_q <= '0;
      duty_sh_q   <= '0;
      presc_cnt_q <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      raw_q       <= 1'b0;
      raw_vld_q   <= 1'b0;
      tgt_q       <= 1'b0;
      tgt_vld_q   <= 1'b0;
      dt_cnt_q    <= '0;
      hi_q        <= 1'b0;
      lo_q        <= 1'b0;
      pwm_q       <= 1'b0;
      pwm_n_q     <= 1'b0;
    end else begin
      en_sh_q     <= en_sh_d;
      pol_sh_q    <= pol_sh_d;
      dt_sh_q     <= dt_sh_d;
      presc_sh_q  <= presc_sh_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      raw_q       <= raw_d;
      raw_vld_q   <= raw_vld_d;
      tgt_q       <= tgt_d;
      tgt_vld_q   <= tgt_vld_d;
      dt_cnt_q    <= dt_cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pwm_q       <= pwm_d;
      pwm_n_q     <= pwm_n_d;
    end
  end

  assign pwm_o         = pwm_q;
  assign pwm_n_o       = pwm_n_q;
  assign period_done_o = done_q;
  assign cnt_o         = cnt_q;

endmodule

// File: tb/tb_spi_pwm_core.sv
// Self-checking bench for spi_pwm_core: table of steady-state waveforms plus
// hand-written sequences for reset, shadowing and disable.
module tb_spi_pwm_core;

  logic       clk;
  logic       rst_n;
  logic [7:0] ctrl;
  logic [7:0] period;
  logic [7:0] duty;
  logic       pwm_o;
  logic       pwm_n_o;
  logic       period_done_o;
  logic [7:0] cnt_o;

  int total;
  int bad;

  spi_pwm_core #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctrl_i        (ctrl),
    .period_i      (period),
    .duty_i        (duty),
    .pwm_o         (pwm_o),
    .pwm_n_o       (pwm_n_o),
    .period_done_o (period_done_o),
    .cnt_o         (cnt_o)
  );

  always #5 clk = ~clk;

  // One steady-state period of pin values, offset 0 = clk where period_done_o is high.
  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] period;
    logic [7:0] duty;
    int         len;
    logic [7:0] pwm_pat;
    logic [7:0] pwmn_pat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic disable_idle();
    ctrl   = 8'h00;
    period = 8'h00;
    duty   = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  // Leaves the bench on the negedge of the second period_done_o pulse.
  task automatic sync_two_periods(input string name, output logic ok);
    int seen;
    seen = 0;
    for (int i = 0; i < 200 && seen < 2; i++) begin
      @(negedge clk);
      if (period_done_o) seen++;
    end
    chk(name, seen, 2);
    ok = (seen == 2);
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    logic ok;
    int   k;
    disable_idle();
    ctrl   = v.ctrl;
    period = v.period;
    duty   = v.duty;
    sync_two_periods($sformatf("v%0d_sync", idx), ok);
    if (ok) begin
      for (int j = 0; j < 2 * v.len; j++) begin
        k = j % v.len;
        chk($sformatf("v%0d_pwm[%0d]", idx, j), pwm_o, v.pwm_pat[k]);
        chk($sformatf("v%0d_pwm_n[%0d]", idx, j), pwm_n_o, v.pwmn_pat[k]);
        chk($sformatf("v%0d_done[%0d]", idx, j), period_done_o, (k == 0));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic       ok;
    logic [7:0] exp_seq;

    total  = 0;
    bad    = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    ctrl   = 8'h00;
    period = 8'h00;
    duty   = 8'h00;

    //          ctrl   N      D      len pwm    pwm_n
    vecs[0] = '{8'h01, 8'd3, 8'd2, 4, 8'h0C, 8'h03};  // basic 50%
    vecs[1] = '{8'h01, 8'd3, 8'd0, 4, 8'h00, 8'h0F};  // D=0
    vecs[2] = '{8'h01, 8'd3, 8'd5, 4, 8'h0F, 8'h00};  // D>N
    vecs[3] = '{8'h01, 8'd3, 8'd3, 4, 8'h0D, 8'h02};  // D=N
    vecs[4] = '{8'h09, 8'd7, 8'd4, 8, 8'h30, 8'h03};  // dead time 2
    vecs[5] = '{8'h13, 8'd1, 8'd1, 4, 8'h03, 8'h0C};  // prescale 1, inverted
    vecs[6] = '{8'h01, 8'd0, 8'd1, 1, 8'h01, 8'h00};  // N=0: wrap every tick
    vecs[7] = '{8'h0D, 8'd3, 8'd5, 4, 8'h0F, 8'h00};  // dt 3, constant high, no gaps

    // Reset values
    #12;
    chk("rst_pwm", pwm_o, 0);
    chk("rst_pwm_n", pwm_n_o, 0);
    chk("rst_done", period_done_o, 0);
    chk("rst_cnt", cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pwm", pwm_o, 0);
    chk("idle_pwm_n", pwm_n_o, 0);
    chk("idle_cnt", cnt_o, 0);

    // Async reset mid-period while pwm_o is high
    ctrl   = 8'h01;
    period = 8'd7;
    duty   = 8'd6;
    ok     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pwm_o && cnt_o != 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("pre_reset_pwm_high", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", pwm_o, 0);
    chk("arst_pwm_n", pwm_n_o, 0);
    chk("arst_cnt", cnt_o, 0);
    chk("arst_done", period_done_o, 0);
    ctrl = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_arst_pwm", pwm_o, 0);
    chk("post_arst_pwm_n", pwm_n_o, 0);
    chk("post_arst_cnt", cnt_o, 0);

    for (int v = 0; v < 8; v++) apply_vec(v, vecs[v]);

    // Shadowing: D 2->1 written while cnt_o=1; current period keeps 2 high clks.
    disable_idle();
    ctrl   = 8'h01;
    period = 8'd3;
    duty   = 8'd2;
    sync_two_periods("shadow_sync", ok);
    if (ok) begin
      @(negedge clk);
      chk("shadow_cnt1", cnt_o, 1);
      duty    = 8'd1;
      exp_seq = 8'h13;  // offsets 2..9: 1,1,0,0,1,0,0,0
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        chk($sformatf("shadow_pwm[%0d]", j + 2), pwm_o, exp_seq[j]);
      end
    end

    // Disable with polarity invert: both pins to 1 within 2 clks, counter cleared.
    disable_idle();
    ctrl   = 8'h13;
    period = 8'd1;
    duty   = 8'd1;
    sync_two_periods("dis_sync", ok);
    if (ok) begin
      repeat (2) @(negedge clk);
      chk("dis_pre_pwm", pwm_o, 0);
      chk("dis_pre_pwm_n", pwm_n_o, 1);
      ctrl = 8'h12;
      repeat (2) @(negedge clk);
      chk("dis_pwm", pwm_o, 1);
      chk("dis_pwm_n", pwm_n_o, 1);
      chk("dis_cnt", cnt_o, 0);
      chk("dis_done", period_done_o, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_pwm_core.md
# spi_pwm_core

PWM generator that consumes the configuration bytes held in the SPI-programmed register bank and drives a complementary, dead-time-protected PWM pin pair. Sits directly downstream of the SPI slave/register block; its three inputs are wired to register-bank entries 1 (ctrl), 2 (period) and 3 (duty). These are already in the `clk` domain, so the block does no synchronisation. Configuration is double-buffered and committed only at period boundaries, so SPI writes never produce glitched pulses.

## Interface
- `WIDTH`, 8: counter, period and duty width.
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ctrl_i`  in  8: [0] enable, [1] output polarity invert, [3:2] dead time in clk cycles (0–3), [7:4] prescale P (tick every P+1 clks).
- `period_i`  in  WIDTH: period value N; the PWM period is N+1 ticks.
- `duty_i`  in  WIDTH: high-side on-time D, in ticks.
- `pwm_o`  out  1: high-side output pin.
- `pwm_n_o`  out  1: low-side (complementary) output pin.
- `period_done_o`  out  1: one-clk pulse after each wrap.
- `cnt_o`  out  WIDTH: current period counter.

## Operation
- **Shadow registers.** `en_sh`, `pol_sh`, `dt_sh`, `presc_sh`, `period_sh` and `duty_sh` hold the active configuration.
  - Disabled (`en_sh`=0): all shadows reload from the inputs on every clk (transparent).
  - Enabled: shadows reload only on a wrap tick.
  - Exception: `ctrl_i[0]`=0 clears `en_sh` on the next clk, at any time.
- **Prescaler.** `presc_cnt` counts 0..`presc_sh`. `tick`=1 when `presc_cnt`==`presc_sh`; the prescaler then returns to 0.
- **Counter.** On each tick, `cnt` increments. If `cnt`==`period_sh`, the tick is a wrap tick instead: `cnt` goes to 0 and the shadows load.
- **Raw PWM.** `raw` = (`cnt` < `duty_sh`), unsigned WIDTH-bit compare.
  - D=0 gives constant low.
  - D > N gives constant high.
- **Output stage.** `raw` is registered into `raw_q`.
  - Every change of `raw_q` drives both logical outputs low and loads `dt_cnt` with `dt_sh`.
  - When `dt_cnt` reaches 0, the new state's output asserts: `hi` = `raw_q`, `lo` = ~`raw_q`.
  - A change of `raw_q` during dead time restarts dead time for the new state.
  - With `dt_sh`=0, `hi`/`lo` follow `raw_q` with no gap.
- **Pins.** `pwm_o` = `hi` ^ `pol_sh`; `pwm_n_o` = `lo` ^ `pol_sh`. Both are registered.
- **Disabled behaviour.** `cnt`, `presc_cnt`, `dt_cnt`, `raw_q`, `hi` and `lo` are held at 0, so both pins equal `pol_sh`. `period_done_o`=0.
- **Enable rise.** On the first enabled clk, `cnt`=0 and `presc_cnt`=0, and the shadows hold the values sampled on the previous clk. The initial `hi`/`lo` state is taken from `raw_q` with dead time applied (`lo` is never asserted before `hi` would be).
- **Async reset.** Clears everything immediately, including mid-period and mid-dead-time.

## Timing
- **Reset values:** `pwm_o`=0, `pwm_n_o`=0, `period_done_o`=0, `cnt_o`=0; all shadows 0.
- **Latency:** pins lag `cnt` by 2 clks (the `raw_q` register plus the output register), plus `dt_sh` clks on the asserting edge only. De-assertion of the active pin occurs 2 clks after the `cnt` change.
- **`period_done_o`:** high for exactly 1 clk, registered from the wrap tick, i.e. coincident with the first clk of `cnt_o`=0. It is one clk long even when P>0.
- **Period length:** (N+1)·(P+1) clks. High-side on-time is D·(P+1) − `dt_sh` clks (clamped at 0) when 0<D≤N.
- **Config changes while enabled:** a change on any input except `ctrl_i[0]` affects the output only from the clk after the next wrap tick.
- **Disable:** `ctrl_i[0]` falling forces the pins to the inactive level within 2 clks, regardless of period position.
- **Wrap-around:** `cnt` never exceeds `period_sh`. If N=0, every tick is a wrap tick.

## Test plan
- **Reset:** assert `rst_n`=0 mid-period with `pwm_o`=1 → both pins, `cnt_o` and `period_done_o` drop to 0 asynchronously; they stay 0 after release until enable.
- **Basic PWM:** ctrl=0x01, N=3, D=2 → `pwm_o` repeats 1,1,0,0; `pwm_n_o` is its complement; `period_done_o` pulses every 4 clks.
- **Duty bounds:** D=0 → `pwm_o` constantly 0, `pwm_n_o` constantly 1. D=5 with N=3 → `pwm_o` constantly 1, `pwm_n_o` 0, no dead-time gaps after settling.
- **Shadowing:** change D from 2 to 1 when `cnt_o`=1 → the current period keeps 2 high clks; the next period has 1.
- **Dead time:** ctrl=0x09 (dt=2), N=7, D=4 → each 8-clk period shows 2 clks both low, 2 clks `pwm_o`=1, 2 clks both low, 2 clks `pwm_n_o`=1.
- **Prescale and polarity:** ctrl=0x13 (P=1, pol=1), N=1, D=1 → period 4 clks; `pwm_o` low for 2 and high for 2 (inverted). Then disable → both pins go to 1 within 2 clks and `cnt_o` goes to 0.
